// File: rtl/speck_encryptor.sv
// Iterative Speck block encryptor: one round per clock, a single shared round
// function, start/done handshake with a registered ciphertext.

module speck_round #(
  parameter int W     = 32,
  parameter int ALPHA = 8,
  parameter int BETA  = 3
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] k,
  output logic [W-1:0] x_nx,
  output logic [W-1:0] y_nx
);
  logic [W-1:0] x_ror;
  logic [W-1:0] y_rol;

  assign x_ror = (x >> ALPHA) | (x << (W - ALPHA));
  assign y_rol = (y << BETA) | (y >> (W - BETA));
  // Sum is W bits wide, so the carry out falls off naturally.
  assign x_nx  = (x_ror + y) ^ k;
  assign y_nx  = y_rol ^ x_nx;
endmodule

module speck_encryptor #(
  parameter int W      = 32,
  parameter int ROUNDS = 27,
  parameter int ALPHA  = 8,
  parameter int BETA   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W-1:0]      pt_x,
  input  logic [W-1:0]      pt_y,
  input  logic [W*ROUNDS-1:0] rk_flat,
  output logic [W-1:0]      ct_x,
  output logic [W-1:0]      ct_y,
  output logic              done,
  output logic              busy
);
  localparam int CW = $clog2(ROUNDS + 1);
  localparam int IW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   x, y, x_nx, y_nx, rk_cur;
  logic [W-1:0]   rk [ROUNDS];
  logic [IW-1:0]  rk_idx;
  logic           last;

  for (genvar g = 0; g < ROUNDS; g++) begin : g_rk
    assign rk[g] = rk_flat[g*W +: W];
  end

  // Clamp keeps the key mux inside rk[] even for counter values never reached.
  assign rk_idx = (cnt < CW'(ROUNDS)) ? cnt[IW-1:0] : IW'(ROUNDS - 1);
  assign rk_cur = rk[rk_idx];
  assign last   = (cnt == CW'(ROUNDS - 1));
  assign busy   = (state == RUN);

  speck_round #(.W(W), .ALPHA(ALPHA), .BETA(BETA)) u_round (
    .x    (x),
    .y    (y),
    .k    (rk_cur),
    .x_nx (x_nx),
    .y_nx (y_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x    <= '0;
      y    <= '0;
      cnt  <= '0;
      ct_x <= '0;
      ct_y <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          x   <= pt_x;
          y   <= pt_y;
          cnt <= '0;
        end
        RUN: begin
          x   <= x_nx;
          y   <= y_nx;
          cnt <= cnt + CW'(1);
          if (last) begin
            ct_x <= x_nx;
            ct_y <= y_nx;
            done <= 1'b1;
            cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
